// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB descriptor-reader types and constants
package usb_pkg;

    localparam logic [7:0] DT_DEVICE = 8'h01;
    localparam logic [7:0] DT_CONFIG = 8'h02;
    localparam logic [7:0] DT_STRING = 8'h03;
    localparam logic [7:0] DT_QUAL   = 8'h06;
    localparam logic [7:0] DT_OSCFG  = 8'h07;
    localparam logic [7:0] DT_BOS    = 8'h0F;
    localparam logic [7:0] DT_HIDRPT = 8'h22;

    localparam int MAXPKT_FS = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LENF,
        ST_SEND,
        ST_WAIT_ACK,
        ST_ZLP
    } state_e;

    typedef struct packed {
        logic [15:0] dev_addr, dev_len, qual_addr, qual_len;
        logic [15:0] fscfg_addr, fscfg_len, hscfg_addr, hscfg_len;
        logic [15:0] hidrpt_addr, hidrpt_len, bos_addr, bos_len;
        logic [15:0] strlang_addr, strven_addr, strven_len;
        logic [15:0] strprod_addr, strprod_len, strser_addr, strser_len;
        logic        have_strings;
    } desc_layout_t;

endpackage

// File: rtl/usb_desc_sel.sv
// rtl/usb_desc_sel.sv - maps a GET_DESCRIPTOR wValue onto a ROM address and length
module usb_desc_sel
    import usb_pkg::*;
(
    input  logic [15:0]  wvalue_i,
    input  logic         hs_mode_i,
    input  desc_layout_t layout_i,
    output logic [15:0]  addr_o,
    output logic [15:0]  len_o,
    output logic         ok_o,
    output logic         need_lenfetch_o,
    output logic         is_oscfg_o
);

    logic [7:0] dtype;
    logic [7:0] idx;

    assign dtype = wvalue_i[15:8];
    assign idx   = wvalue_i[7:0];

    always_comb begin
        addr_o          = '0;
        len_o           = '0;
        ok_o            = 1'b0;
        need_lenfetch_o = 1'b0;
        is_oscfg_o      = 1'b0;
        case (dtype)
            DT_DEVICE: begin
                addr_o = layout_i.dev_addr;
                len_o  = layout_i.dev_len;
                ok_o   = 1'b1;
            end
            DT_QUAL: begin
                addr_o = layout_i.qual_addr;
                len_o  = layout_i.qual_len;
                ok_o   = 1'b1;
            end
            DT_CONFIG, DT_OSCFG: begin
                is_oscfg_o = (dtype == DT_OSCFG);
                ok_o       = (idx == 8'd0);
                // Other-speed returns the configuration for the speed we are not running at
                if (hs_mode_i ^ is_oscfg_o) begin
                    addr_o = layout_i.hscfg_addr;
                    len_o  = layout_i.hscfg_len;
                end else begin
                    addr_o = layout_i.fscfg_addr;
                    len_o  = layout_i.fscfg_len;
                end
            end
            DT_HIDRPT: begin
                addr_o = layout_i.hidrpt_addr;
                len_o  = layout_i.hidrpt_len;
                ok_o   = 1'b1;
            end
            DT_BOS: begin
                addr_o = layout_i.bos_addr;
                len_o  = layout_i.bos_len;
                ok_o   = 1'b1;
            end
            DT_STRING: begin
                ok_o = layout_i.have_strings && (idx < 8'd4);
                case (idx)
                    8'd0: begin
                        addr_o          = layout_i.strlang_addr;
                        need_lenfetch_o = 1'b1;
                    end
                    8'd1: begin
                        addr_o = layout_i.strven_addr;
                        len_o  = layout_i.strven_len;
                    end
                    8'd2: begin
                        addr_o = layout_i.strprod_addr;
                        len_o  = layout_i.strprod_len;
                    end
                    8'd3: begin
                        addr_o = layout_i.strser_addr;
                        len_o  = layout_i.strser_len;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/usb_desc_reader.sv
// rtl/usb_desc_reader.sv - EP0 GET_DESCRIPTOR data-stage engine (packetise, retry, ZLP, stall)
module usb_desc_reader
    import usb_pkg::*;
#(
    parameter int MAXPKT = MAXPKT_FS,
    parameter int AW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    input  logic [15:0]   req_wvalue_i,
    input  logic [15:0]   req_wlength_i,
    input  logic          hs_mode_i,
    input  logic          abort_i,
    output logic [AW-1:0] descrom_raddr_o,
    input  logic [7:0]    descrom_rdata_i,
    input  logic [15:0]   desc_dev_addr_i,
    input  logic [15:0]   desc_dev_len_i,
    input  logic [15:0]   desc_qual_addr_i,
    input  logic [15:0]   desc_qual_len_i,
    input  logic [15:0]   desc_fscfg_addr_i,
    input  logic [15:0]   desc_fscfg_len_i,
    input  logic [15:0]   desc_hscfg_addr_i,
    input  logic [15:0]   desc_hscfg_len_i,
    input  logic [15:0]   desc_hidrpt_addr_i,
    input  logic [15:0]   desc_hidrpt_len_i,
    input  logic [15:0]   desc_bos_addr_i,
    input  logic [15:0]   desc_bos_len_i,
    input  logic [15:0]   desc_strlang_addr_i,
    input  logic [15:0]   desc_strven_addr_i,
    input  logic [15:0]   desc_strven_len_i,
    input  logic [15:0]   desc_strprod_addr_i,
    input  logic [15:0]   desc_strprod_len_i,
    input  logic [15:0]   desc_strser_addr_i,
    input  logic [15:0]   desc_strser_len_i,
    input  logic          desc_have_strings_i,
    output logic [7:0]    tx_data_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic          tx_last_o,
    output logic          tx_zlp_o,
    input  logic          pkt_ack_i,
    input  logic          pkt_retry_i,
    output logic          busy_o,
    output logic          stall_o,
    output logic          done_o
);

    localparam int PW = $clog2(MAXPKT);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d, snap_addr_q, snap_addr_d;
    logic [15:0]     rem_q, rem_d, snap_rem_q, snap_rem_d;
    logic [15:0]     total_q, total_d, wlen_q, wlen_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            oscfg_q, oscfg_d, done_q, done_d, stall_q, stall_d, zlp_q, zlp_d;

    desc_layout_t    layout;
    logic [15:0]     sel_addr, sel_len, req_total, lenf_len, lenf_total;
    logic            sel_ok, sel_lenfetch, sel_oscfg, xfer, oscfg_byte;

    assign layout = '{
        dev_addr: desc_dev_addr_i,         dev_len: desc_dev_len_i,
        qual_addr: desc_qual_addr_i,       qual_len: desc_qual_len_i,
        fscfg_addr: desc_fscfg_addr_i,     fscfg_len: desc_fscfg_len_i,
        hscfg_addr: desc_hscfg_addr_i,     hscfg_len: desc_hscfg_len_i,
        hidrpt_addr: desc_hidrpt_addr_i,   hidrpt_len: desc_hidrpt_len_i,
        bos_addr: desc_bos_addr_i,         bos_len: desc_bos_len_i,
        strlang_addr: desc_strlang_addr_i,
        strven_addr: desc_strven_addr_i,   strven_len: desc_strven_len_i,
        strprod_addr: desc_strprod_addr_i, strprod_len: desc_strprod_len_i,
        strser_addr: desc_strser_addr_i,   strser_len: desc_strser_len_i,
        have_strings: desc_have_strings_i
    };

    usb_desc_sel u_sel (
        .wvalue_i        (req_wvalue_i),
        .hs_mode_i       (hs_mode_i),
        .layout_i        (layout),
        .addr_o          (sel_addr),
        .len_o           (sel_len),
        .ok_o            (sel_ok),
        .need_lenfetch_o (sel_lenfetch),
        .is_oscfg_o      (sel_oscfg)
    );

    assign req_total  = (sel_len < req_wlength_i) ? sel_len : req_wlength_i;
    assign lenf_len   = {8'h00, descrom_rdata_i};
    assign lenf_total = (lenf_len < wlen_q) ? lenf_len : wlen_q;

    // Other-speed config is served from the normal config image with bDescriptorType patched
    assign oscfg_byte = oscfg_q && ((total_q - rem_q) == 16'd1);

    assign tx_valid_o      = (state_q == ST_SEND);
    assign tx_data_o       = !tx_valid_o ? 8'h00 : (oscfg_byte ? DT_OSCFG : descrom_rdata_i);
    assign tx_last_o       = tx_valid_o && ((rem_q == 16'd1) || (pcnt_q == PW'(MAXPKT - 1)));
    assign xfer            = tx_valid_o && tx_ready_i;
    assign descrom_raddr_o = addr_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign stall_o         = stall_q;
    assign done_o          = done_q;
    assign tx_zlp_o        = zlp_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        total_d     = total_q;
        wlen_d      = wlen_q;
        snap_addr_d = snap_addr_q;
        snap_rem_d  = snap_rem_q;
        pcnt_d      = pcnt_q;
        oscfg_d     = oscfg_q;
        done_d      = 1'b0;
        stall_d     = 1'b0;
        zlp_d       = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid_i) begin
                    wlen_d  = req_wlength_i;
                    oscfg_d = sel_oscfg;
                    addr_d  = AW'(sel_addr);
                    if (!sel_ok) begin
                        stall_d = 1'b1;
                    end else if (req_wlength_i == 16'd0 || (!sel_lenfetch && req_total == 16'd0)) begin
                        done_d = 1'b1;
                    end else if (sel_lenfetch) begin
                        state_d = ST_LENF;
                    end else begin
                        rem_d       = req_total;
                        total_d     = req_total;
                        snap_addr_d = AW'(sel_addr);
                        snap_rem_d  = req_total;
                        pcnt_d      = '0;
                        state_d     = ST_SEND;
                    end
                end
                ST_LENF: begin
                    rem_d       = lenf_total;
                    total_d     = lenf_total;
                    snap_addr_d = addr_q;
                    snap_rem_d  = lenf_total;
                    pcnt_d      = '0;
                    if (lenf_total == 16'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: if (xfer) begin
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - 16'd1;
                    pcnt_d = pcnt_q + PW'(1);
                    if (tx_last_o) state_d = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (pkt_retry_i) begin
                        addr_d  = snap_addr_q;
                        rem_d   = snap_rem_q;
                        pcnt_d  = '0;
                        state_d = ST_SEND;
                    end else if (pkt_ack_i) begin
                        if (rem_q != 16'd0) begin
                            snap_addr_d = addr_q;
                            snap_rem_d  = rem_q;
                            pcnt_d      = '0;
                            state_d     = ST_SEND;
                        end else if (total_q[PW-1:0] == '0 && total_q < wlen_q) begin
                            zlp_d   = 1'b1;
                            state_d = ST_ZLP;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ZLP: begin
                    if (pkt_retry_i) begin
                        zlp_d = 1'b1;
                    end else if (pkt_ack_i) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            total_q     <= '0;
            wlen_q      <= '0;
            snap_addr_q <= '0;
            snap_rem_q  <= '0;
            pcnt_q      <= '0;
            oscfg_q     <= 1'b0;
            done_q      <= 1'b0;
            stall_q     <= 1'b0;
            zlp_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            total_q     <= total_d;
            wlen_q      <= wlen_d;
            snap_addr_q <= snap_addr_d;
            snap_rem_q  <= snap_rem_d;
            pcnt_q      <= pcnt_d;
            oscfg_q     <= oscfg_d;
            done_q      <= done_d;
            stall_q     <= stall_d;
            zlp_q       <= zlp_d;
        end
    end

endmodule

// File: tb/tb_usb_desc_reader.sv
// tb/tb_usb_desc_reader.sv - randomized self-checking bench for usb_desc_reader
module tb_usb_desc_reader;

    localparam int MP = 8;
    localparam int AW = 16;
    localparam int DEV_A = 0,    DEV_L = 18,  FS_A = 28,    FS_L = 67,  HS_A = 96,  HS_L = 67;
    localparam int QUAL_A = 163, QUAL_L = 10, BOS_A = 173,  BOS_L = 24, LANG_A = 197;
    localparam int VEN_A = 201,  VEN_L = 6,   PROD_A = 207, PROD_L = 8, SER_A = 215, SER_L = 10;
    localparam int HID_A = 225,  HID_L = 20;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req_valid = 1'b0, hs_mode = 1'b0, abort = 1'b0, have_strings = 1'b1;
    logic [15:0]   wvalue = '0, wlength = '0;
    logic [AW-1:0] raddr;
    logic [7:0]    rdata, tx_data;
    logic          tx_valid, tx_ready = 1'b0, tx_last, tx_zlp, pkt_ack = 1'b0, pkt_retry = 1'b0;
    logic          busy, stall, done;
    logic [7:0]    rom [0:65535];

    int n_total = 0, n_bad = 0;
    logic [8:0] exp_q[$], obs_q[$];
    int exp_zlp, exp_done, exp_stall;
    int obs_zlp, obs_done, obs_stall, obs_hold_err, obs_timeout;

    always #5 clk = ~clk;
    assign rdata = rom[raddr];

    usb_desc_reader #(.MAXPKT(MP), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_wvalue_i(wvalue),
        .req_wlength_i(wlength), .hs_mode_i(hs_mode), .abort_i(abort),
        .descrom_raddr_o(raddr), .descrom_rdata_i(rdata),
        .desc_dev_addr_i(16'(DEV_A)), .desc_dev_len_i(16'(DEV_L)),
        .desc_qual_addr_i(16'(QUAL_A)), .desc_qual_len_i(16'(QUAL_L)),
        .desc_fscfg_addr_i(16'(FS_A)), .desc_fscfg_len_i(16'(FS_L)),
        .desc_hscfg_addr_i(16'(HS_A)), .desc_hscfg_len_i(16'(HS_L)),
        .desc_hidrpt_addr_i(16'(HID_A)), .desc_hidrpt_len_i(16'(HID_L)),
        .desc_bos_addr_i(16'(BOS_A)), .desc_bos_len_i(16'(BOS_L)),
        .desc_strlang_addr_i(16'(LANG_A)),
        .desc_strven_addr_i(16'(VEN_A)), .desc_strven_len_i(16'(VEN_L)),
        .desc_strprod_addr_i(16'(PROD_A)), .desc_strprod_len_i(16'(PROD_L)),
        .desc_strser_addr_i(16'(SER_A)), .desc_strser_len_i(16'(SER_L)),
        .desc_have_strings_i(have_strings),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_last_o(tx_last),
        .tx_zlp_o(tx_zlp), .pkt_ack_i(pkt_ack), .pkt_retry_i(pkt_retry),
        .busy_o(busy), .stall_o(stall), .done_o(done)
    );

    // Reference: which descriptor a wValue names, straight from the request rules
    task automatic lookup(input logic [15:0] wv, input logic hs, output bit ok, output int a, output int l, output bit os);
        logic [7:0] t, i;
        t = wv[15:8]; i = wv[7:0]; ok = 1; os = 0; a = 0; l = 0;
        case (t)
            8'h01: begin a = DEV_A; l = DEV_L; end
            8'h06: begin a = QUAL_A; l = QUAL_L; end
            8'h02: begin ok = (i == 0); a = hs ? HS_A : FS_A; l = hs ? HS_L : FS_L; end
            8'h07: begin ok = (i == 0); os = 1; a = hs ? FS_A : HS_A; l = hs ? FS_L : HS_L; end
            8'h22: begin a = HID_A; l = HID_L; end
            8'h0F: begin a = BOS_A; l = BOS_L; end
            8'h03: begin
                ok = have_strings && (i <= 3);
                if (i == 0) begin a = LANG_A; l = int'(rom[LANG_A]); end
                else if (i == 1) begin a = VEN_A; l = VEN_L; end
                else if (i == 2) begin a = PROD_A; l = PROD_L; end
                else begin a = SER_A; l = SER_L; end
            end
            default: ok = 0;
        endcase
    endtask

    task automatic build_expected(input logic [15:0] wv, input int wl, input logic hs, input int retry_pkt);
        bit ok, os; int a, l, tot, npk, e;
        lookup(wv, hs, ok, a, l, os);
        exp_q.delete();
        exp_stall = ok ? 0 : 1; exp_done = ok ? 1 : 0; exp_zlp = 0;
        if (!ok) return;
        tot = (l < wl) ? l : wl;
        npk = (tot + MP - 1) / MP;
        for (int p = 0; p < npk; p++) begin
            e = (p * MP + MP < tot) ? p * MP + MP : tot;
            for (int r = 0; r < ((p == retry_pkt) ? 2 : 1); r++)
                for (int b = p * MP; b < e; b++)
                    exp_q.push_back({(b == e - 1), ((os && b == 1) ? 8'h07 : rom[a + b])});
        end
        exp_zlp = (tot > 0 && tot % MP == 0 && tot < wl) ? 1 : 0;
    endtask

    // Plays host + packet transmitter: random ready, delayed ACK, optional single retry
    task automatic do_transfer(input logic [15:0] wv, input logic [15:0] wl, input logic hs, input int retry_pkt);
        int pending = 0, pkt = 0; bit pend_zlp = 0, retried = 0, held = 0, fin = 0; logic [7:0] held_data = 0;
        obs_q.delete(); obs_zlp = 0; obs_done = 0; obs_stall = 0; obs_hold_err = 0; obs_timeout = 0;
        @(negedge clk); req_valid = 1; wvalue = wv; wlength = wl; hs_mode = hs;
        @(negedge clk); req_valid = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            pkt_ack = 0; pkt_retry = 0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    if (!pend_zlp && pkt == retry_pkt && !retried) begin pkt_retry = 1; retried = 1; end
                    else begin pkt_ack = 1; if (!pend_zlp) pkt++; end
                end
            end
            if (stall) begin obs_stall++; fin = 1; end
            if (done) begin obs_done++; fin = 1; end
            if (tx_zlp) begin obs_zlp++; pending = 1 + $urandom_range(0, 3); pend_zlp = 1; end
            if (tx_valid) begin
                if (held && tx_data !== held_data) obs_hold_err++;
                tx_ready = ($urandom_range(0, 3) != 0);
                if (tx_ready) begin
                    obs_q.push_back({tx_last, tx_data}); held = 0;
                    if (tx_last) begin pending = 1 + $urandom_range(0, 3); pend_zlp = 0; end
                end else begin held = 1; held_data = tx_data; end
            end else begin
                held = 0; tx_ready = $urandom_range(0, 1);
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) obs_timeout = 1;
        tx_ready = 0; pkt_ack = 0; pkt_retry = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++; if ({tx_valid, tx_last, tx_zlp, busy, stall, done} !== 6'b0) begin n_bad++;
            $display("FAIL reset_flags got=%b exp=000000", {tx_valid, tx_last, tx_zlp, busy, stall, done}); end
        n_total++; if (raddr !== '0) begin n_bad++; $display("FAIL reset_raddr got=%h exp=0000", raddr); end
        n_total++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", tx_data); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_device();
        build_expected(16'h0100, 16'h0040, 0, -1);
        do_transfer(16'h0100, 16'h0040, 0, -1);
        n_total++; if (obs_q.size() != 18) begin n_bad++; $display("FAIL dev_len got=%0d exp=18", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++; if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL dev_byte[%0d] got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : 9'h0, exp_q[i]); end
        end
        if (obs_q.size() >= 18) begin
            n_total++; if ({obs_q[0][7:0], obs_q[1][7:0], obs_q[2][7:0], obs_q[3][7:0]} !== 32'h12011001) begin n_bad++;
                $display("FAIL dev_head got=%h%h%h%h exp=12011001", obs_q[0][7:0], obs_q[1][7:0], obs_q[2][7:0], obs_q[3][7:0]); end
            n_total++; if ({obs_q[7][8], obs_q[15][8], obs_q[17][8], obs_q[6][8]} !== 4'b1110) begin n_bad++;
                $display("FAIL dev_last got=%b exp=1110", {obs_q[7][8], obs_q[15][8], obs_q[17][8], obs_q[6][8]}); end
        end
        n_total++; if ({obs_zlp, obs_done, obs_hold_err, obs_timeout} !== {32'd0, 32'd1, 32'd0, 32'd0}) begin n_bad++;
            $display("FAIL dev_status got zlp=%0d done=%0d hold=%0d to=%0d exp 0 1 0 0", obs_zlp, obs_done, obs_hold_err, obs_timeout); end
    endtask

    task automatic test_oscfg();
        build_expected(16'h0700, 16'h00FF, 1, -1);
        do_transfer(16'h0700, 16'h00FF, 1, -1);
        n_total++; if (obs_q.size() != 67) begin n_bad++; $display("FAIL oscfg_len got=%0d exp=67", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++; if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL oscfg_byte[%0d] got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : 9'h0, exp_q[i]); end
        end
        if (obs_q.size() >= 4) begin
            n_total++; if ({obs_q[1][7:0], obs_q[2][7:0], obs_q[3][7:0]} !== 24'h074300) begin n_bad++;
                $display("FAIL oscfg_head got=%h%h%h exp=074300", obs_q[1][7:0], obs_q[2][7:0], obs_q[3][7:0]); end
        end
        n_total++; if (obs_done != 1 || obs_zlp != 0) begin n_bad++; $display("FAIL oscfg_end got done=%0d zlp=%0d exp 1 0", obs_done, obs_zlp); end
    endtask

    task automatic test_strlang();
        do_transfer(16'h0300, 16'h00FF, 0, -1);
        n_total++; if (obs_q.size() != 4) begin n_bad++; $display("FAIL lang_len got=%0d exp=4", obs_q.size()); end
        else begin
            n_total++; if ({obs_q[0], obs_q[1], obs_q[2], obs_q[3]} !== {9'h004, 9'h003, 9'h009, 9'h104}) begin n_bad++;
                $display("FAIL lang_bytes got=%h %h %h %h exp=004 003 009 104", obs_q[0], obs_q[1], obs_q[2], obs_q[3]); end
        end
        n_total++; if (obs_done != 1) begin n_bad++; $display("FAIL lang_done got=%0d exp=1", obs_done); end
    endtask

    task automatic test_bos_zlp();
        do_transfer(16'h0F00, 16'h00FF, 0, -1);
        n_total++; if (obs_q.size() != 24 || obs_zlp != 1 || obs_done != 1) begin n_bad++;
            $display("FAIL bos_zlp got len=%0d zlp=%0d done=%0d exp 24 1 1", obs_q.size(), obs_zlp, obs_done); end
        do_transfer(16'h0F00, 16'd24, 0, -1);
        n_total++; if (obs_q.size() != 24 || obs_zlp != 0 || obs_done != 1) begin n_bad++;
            $display("FAIL bos_exact got len=%0d zlp=%0d done=%0d exp 24 0 1", obs_q.size(), obs_zlp, obs_done); end
    endtask

    task automatic test_retry();
        build_expected(16'h0100, 16'h0040, 0, 1);
        do_transfer(16'h0100, 16'h0040, 0, 1);
        n_total++; if (obs_q.size() != 26) begin n_bad++; $display("FAIL retry_len got=%0d exp=26", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++; if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL retry_byte[%0d] got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : 9'h0, exp_q[i]); end
        end
        if (obs_q.size() >= 18) begin
            n_total++; if ({obs_q[8][7:0], obs_q[9][7:0], obs_q[16][7:0], obs_q[17][7:0]} !== 32'h00020002) begin n_bad++;
                $display("FAIL retry_resend got=%h%h%h%h exp=00020002", obs_q[8][7:0], obs_q[9][7:0], obs_q[16][7:0], obs_q[17][7:0]); end
        end
    endtask

    task automatic test_stall();
        logic [15:0] wv_tab [4] = '{16'h0500, 16'h0304, 16'h0201, 16'h0301};
        for (int k = 0; k < 4; k++) begin
            have_strings = (k != 3);
            do_transfer(wv_tab[k], 16'h0040, 0, -1);
            n_total++; if (obs_stall != 1 || obs_done != 0 || obs_q.size() != 0) begin n_bad++;
                $display("FAIL stall_%h got stall=%0d done=%0d bytes=%0d exp 1 0 0", wv_tab[k], obs_stall, obs_done, obs_q.size()); end
            @(negedge clk);
            n_total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin n_bad++;
                $display("FAIL stall_after_%h got valid=%b busy=%b stall=%b exp 0 0 0", wv_tab[k], tx_valid, busy, stall); end
        end
        have_strings = 1;
    endtask

    task automatic test_wlength_zero();
        do_transfer(16'h0100, 16'h0000, 0, -1);
        n_total++; if (obs_done != 1 || obs_q.size() != 0 || obs_timeout != 0) begin n_bad++;
            $display("FAIL wlen0 got done=%0d bytes=%0d to=%0d exp 1 0 0", obs_done, obs_q.size(), obs_timeout); end
    endtask

    task automatic test_abort();
        int seen = 0; bit got_done = 0;
        @(negedge clk); req_valid = 1; wvalue = 16'h0100; wlength = 16'h0040; hs_mode = 0;
        @(negedge clk); req_valid = 0; tx_ready = 1;
        for (int c = 0; c < 20 && seen < 4; c++) begin if (tx_valid) seen++; @(negedge clk); end
        n_total++; if (seen != 4) begin n_bad++; $display("FAIL abort_start got=%0d exp=4", seen); end
        abort = 1;
        @(negedge clk); abort = 0; tx_ready = 0;
        n_total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL abort_idle got valid=%b busy=%b exp 0 0", tx_valid, busy); end
        for (int c = 0; c < 6; c++) begin if (done) got_done = 1; @(negedge clk); end
        n_total++; if (got_done) begin n_bad++; $display("FAIL abort_done got=1 exp=0"); end
    endtask

    task automatic test_random();
        logic [15:0] wv_tab [12] = '{16'h0100, 16'h0600, 16'h0200, 16'h0201, 16'h0700, 16'h2200,
                                     16'h0F00, 16'h0300, 16'h0301, 16'h0302, 16'h0303, 16'h0500};
        logic [15:0] wv, wl; logic hs; int rp;
        for (int it = 0; it < 30; it++) begin
            wv = wv_tab[$urandom_range(0, 11)]; hs = $urandom_range(0, 1);
            rp = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: wl = 16'd0;
                1: wl = 16'd1;
                2: wl = 16'($urandom_range(1, 300));
                3: wl = 16'(MP * $urandom_range(1, 4));
                4: wl = 16'hFFFF;
                default: wl = 16'($urandom_range(1, 70));
            endcase
            have_strings = ($urandom_range(0, 5) != 0);
            build_expected(wv, int'(wl), hs, rp);
            do_transfer(wv, wl, hs, rp);
            n_total++; if (obs_q.size() != exp_q.size()) begin n_bad++;
                $display("FAIL rnd%0d_len wv=%h wl=%0d got=%0d exp=%0d", it, wv, wl, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_total++; if (obs_q[i] !== exp_q[i]) begin n_bad++;
                    $display("FAIL rnd%0d_byte[%0d] got=%h exp=%h", it, i, obs_q[i], exp_q[i]); end
            end
            n_total++; if ({obs_zlp, obs_done, obs_stall, obs_hold_err, obs_timeout} !== {exp_zlp, exp_done, exp_stall, 32'd0, 32'd0}) begin n_bad++;
                $display("FAIL rnd%0d_status wv=%h wl=%0d got zlp=%0d done=%0d stall=%0d hold=%0d to=%0d exp %0d %0d %0d 0 0",
                         it, wv, wl, obs_zlp, obs_done, obs_stall, obs_hold_err, obs_timeout, exp_zlp, exp_done, exp_stall); end
        end
        have_strings = 1;
    endtask

    initial begin
        logic [143:0] dev_img;
        dev_img = 144'h120110010000000800020102000101020301;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 18; i++) rom[DEV_A + i] = dev_img[143 - 8 * i -: 8];
        rom[FS_A] = 8'h09; rom[FS_A + 1] = 8'h02; rom[FS_A + 2] = 8'h43; rom[FS_A + 3] = 8'h00;
        rom[HS_A] = 8'h09; rom[HS_A + 1] = 8'h02; rom[HS_A + 2] = 8'h43; rom[HS_A + 3] = 8'h00;
        rom[LANG_A] = 8'h04; rom[LANG_A + 1] = 8'h03; rom[LANG_A + 2] = 8'h09; rom[LANG_A + 3] = 8'h04;
        test_reset();
        test_device();
        test_oscfg();
        test_strlang();
        test_bos_zlp();
        test_retry();
        test_stall();
        test_wlength_zero();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
